// File: rtl/loader_pkg.sv
// Shared constants for the boot-time instruction memory loader.
package loader_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR_LO = 3'd1;
    localparam logic [2:0] HDR_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CHK    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    localparam int HDR_BYTES = 2;

    // States in which the loader takes bytes from the stream.
    function automatic logic is_ready_state(input logic [2:0] s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] shift_q, shift_d;

    // Bytes enter at the top and drift down, so the first byte ends up in [7:0].
    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clear) begin
            lane_d  = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid) begin
            lane_d  = lane_q + 2'd1;
            shift_d = {byte_data, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

    assign word       = {byte_data, shift_q};
    assign word_ready = byte_valid && (lane_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed image into instruction memory and holds the core in reset
// until it is written. Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code
);

    localparam logic [16:0] CAPACITY = 17'(2**ADDR_W);
    localparam logic [16:0] BASE17   = 17'(BASE_ADDR);

    logic [2:0]        state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        xfer;
    logic        pack_clear;
    logic        pack_valid;
    logic [31:0] pack_word;
    logic        pack_ready;
    logic [15:0] n_hdr;
    logic [16:0] end_addr;

    assign xfer       = in_valid && in_ready_q;
    assign pack_valid = xfer && (state_q == DATA);
    assign n_hdr      = {in_data, count_q[7:0]};
    assign end_addr   = BASE17 + {1'b0, n_hdr};

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_data  (in_data),
        .word       (pack_word),
        .word_ready (pack_ready)
    );

    // Overflow is judged on the 17-bit end address so an oversized image never writes.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        pack_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = HDR_LO;
                    done_d     = 1'b0;
                    err_d      = ERR_NONE;
                    hold_d     = 1'b1;
                    count_d    = 16'd0;
                    word_idx_d = 16'd0;
                    pack_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end else if (state_q == DONE) begin
                    hold_d = 1'b0;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    count_d = {count_q[15:8], in_data};
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    count_d = n_hdr;
                    if (end_addr > CAPACITY) begin
                        state_d = ERR;
                        err_d   = ERR_OVF;
                    end else if (n_hdr == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + in_data;
`endif
                    if (pack_ready) begin
                        we_d       = 1'b1;
                        addr_d     = ADDR_W'(BASE17 + {1'b0, word_idx_q});
                        wdata_d    = pack_word;
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        in_ready_d = is_ready_state(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= 16'd0;
            word_idx_q <= 16'd0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign busy       = is_ready_state(state_q);
    assign done       = done_q;
    assign err_code   = err_q;

endmodule
